// File: rtl/dct_blk_arb.sv
`default_nettype none
// ============================================================================
// Module   : dct_blk_arb
// Brief    : Block-granular round-robin arbiter feeding one DCT row pipeline.
//            Optional source-tag FIFO enabled by macro DCT_ARB_TAG_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dct_blk_arb #(
    parameter int N_SRC     = 3,
    parameter int W_I       = 8,
    parameter int ROWS      = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_SRC-1:0]           req_valid,
    output logic [N_SRC-1:0]           req_ready,
    input  logic [N_SRC*8*W_I-1:0]     req_data,
    input  logic [N_SRC-1:0]           req_sob,
    input  logic [N_SRC-1:0]           req_eob,
    input  logic [N_SRC-1:0]           req_sof,
    output logic                       dct_valid,
    output logic [8*W_I-1:0]           dct_data,
    output logic                       dct_sob,
    output logic                       dct_eob,
    output logic                       dct_sof,
    output logic [$clog2(N_SRC)-1:0]   dct_src,
`ifdef DCT_ARB_TAG_FIFO_EN
    input  logic                       dct_out_valid,
    input  logic                       dct_out_sob,
    output logic [$clog2(N_SRC)-1:0]   out_src,
    output logic                       out_src_valid,
`endif
    output logic                       proto_err
);

    localparam int c_SRC_W = $clog2(N_SRC);
    localparam int c_CNT_W = $clog2(ROWS + 1);
    localparam int c_ROW_W = 8 * W_I;
    localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_SRC_W-1:0]   r_grant, w_grant_nxt;
    logic [c_SRC_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [c_CNT_W-1:0]   r_row_cnt, w_cnt_nxt;

    logic [N_SRC-1:0]     w_cand, w_orphan;
    logic                 w_win_found, w_drop_found;
    logic [c_SRC_W-1:0]   w_win, w_drop, w_sel;
    logic                 w_xfer, w_out_sob, w_out_eob, w_out_sof, w_err;
    logic                 w_last;
    logic [c_ROW_W-1:0]   w_row_data;
    logic                 w_tag_full, w_tag_pop_err;

    logic                 r_dct_valid, r_dct_sob, r_dct_eob, r_dct_sof, r_err;
    logic [c_ROW_W-1:0]   r_dct_data;
    logic [c_SRC_W-1:0]   r_dct_src;

    assign w_cand   = req_valid & req_sob;
    assign w_orphan = req_valid & ~req_sob;
    assign w_last   = (r_row_cnt == c_LAST_ROW);

    // Round-robin scan starting just after the last finished owner.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_win_found = 1'b0;
        w_win       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N_SRC) v_idx = v_idx - N_SRC;
            if (!w_win_found && w_cand[v_idx]) begin
                w_win_found = 1'b1;
                w_win       = c_SRC_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_drop_found = 1'b0;
        w_drop       = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_orphan[i]) begin
                w_drop_found = 1'b1;
                w_drop       = c_SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= c_SRC_W'(N_SRC - 1);
            r_row_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_row_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_row_cnt;
        req_ready   = '0;
        w_xfer      = 1'b0;
        w_sel       = r_grant;
        w_out_sob   = 1'b0;
        w_out_eob   = 1'b0;
        w_out_sof   = 1'b0;
        w_err       = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    w_sel = w_win;
                    if (w_win_found && !w_tag_full) begin
                        req_ready[w_win] = 1'b1;
                        w_xfer      = 1'b1;
                        w_out_sob   = 1'b1;
                        w_out_sof   = req_sof[w_win];
                        w_grant_nxt = w_win;
                        if (req_eob[w_win] || (ROWS == 1)) begin
                            // Single-row block: closes immediately.
                            w_out_eob = 1'b1;
                            w_rr_nxt  = w_win;
                            w_err     = !req_eob[w_win];
                        end else begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = c_CNT_W'(1);
                        end
                    end else if (!w_win_found && w_drop_found) begin
                        req_ready[w_drop] = 1'b1;
                        w_err = 1'b1;
                    end
                end
                ST_BUSY: begin
                    req_ready[r_grant] = 1'b1;
                    if (req_valid[r_grant]) begin
                        w_xfer    = 1'b1;
                        w_out_eob = req_eob[r_grant] || w_last;
                        w_cnt_nxt = r_row_cnt + 1'b1;
                        // Mid-block sob/sof, early eob and missing eob are all violations.
                        w_err = req_sob[r_grant] || req_sof[r_grant] ||
                                (req_eob[r_grant] != w_last);
                        if (w_out_eob) begin
                            w_state_nxt = ST_IDLE;
                            w_rr_nxt    = r_grant;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_row_data = req_data[int'(w_sel) * c_ROW_W +: c_ROW_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dct_valid <= 1'b0;
            r_dct_data  <= '0;
            r_dct_sob   <= 1'b0;
            r_dct_eob   <= 1'b0;
            r_dct_sof   <= 1'b0;
            r_dct_src   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_dct_valid <= w_xfer;
            r_dct_sob   <= w_xfer && w_out_sob;
            r_dct_eob   <= w_xfer && w_out_eob;
            r_dct_sof   <= w_xfer && w_out_sof;
            r_err       <= w_err || w_tag_pop_err;
            if (w_xfer) begin
                r_dct_data <= w_row_data;
                r_dct_src  <= w_sel;
            end
        end
    end

    assign dct_valid = r_dct_valid;
    assign dct_data  = r_dct_data;
    assign dct_sob   = r_dct_sob;
    assign dct_eob   = r_dct_eob;
    assign dct_sof   = r_dct_sof;
    assign dct_src   = r_dct_src;
    assign proto_err = r_err;

`ifdef DCT_ARB_TAG_FIFO_EN
    localparam int c_TAG_AW = $clog2(TAG_DEPTH);

    logic [c_SRC_W-1:0]  r_tag_mem [TAG_DEPTH];
    logic [c_TAG_AW-1:0] r_tag_wr, r_tag_rd;
    logic [c_TAG_AW:0]   r_tag_cnt;
    logic                w_tag_empty, w_tag_pop_req, w_tag_pop, w_tag_push;

    assign w_tag_empty   = (r_tag_cnt == '0);
    assign w_tag_pop_req = dct_out_valid && dct_out_sob;
    assign w_tag_pop     = w_tag_pop_req && !w_tag_empty;
    assign w_tag_pop_err = w_tag_pop_req && w_tag_empty;
    // A pop in the same cycle frees the slot the new block's tag needs.
    assign w_tag_full    = (r_tag_cnt == (c_TAG_AW + 1)'(TAG_DEPTH)) && !w_tag_pop;
    assign w_tag_push    = w_xfer && w_out_sob;

    always_ff @(posedge clk) begin
        if (w_tag_push) r_tag_mem[r_tag_wr] <= w_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_tag_push) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_tag_pop)  r_tag_rd <= r_tag_rd + 1'b1;
            if (w_tag_push && !w_tag_pop)      r_tag_cnt <= r_tag_cnt + 1'b1;
            else if (!w_tag_push && w_tag_pop) r_tag_cnt <= r_tag_cnt - 1'b1;
        end
    end

    assign out_src       = w_tag_empty ? '0 : r_tag_mem[r_tag_rd];
    assign out_src_valid = !w_tag_empty;
`else
    // No tag FIFO: grants are never throttled.
    assign w_tag_full    = (TAG_DEPTH == 0);
    assign w_tag_pop_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dct_blk_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_blk_arb
// Brief    : Directed self-checking bench for dct_blk_arb with a per-cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_blk_arb;

    localparam int N    = 3;
    localparam int W_I  = 8;
    localparam int ROWS = 8;
    localparam int DW   = 8 * W_I;
    localparam int SW   = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sob;
        logic          eob;
        logic          sof;
    } row_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, req_sob = '0, req_eob = '0, req_sof = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            dct_valid, dct_sob, dct_eob, dct_sof, proto_err;
    logic [DW-1:0]   dct_data;
    logic [SW-1:0]   dct_src;
`ifdef DCT_ARB_TAG_FIFO_EN
    logic [SW-1:0]   out_src;
    logic            out_src_valid;
`endif

    always #5 clk = ~clk;

    dct_blk_arb #(.N_SRC(N), .W_I(W_I), .ROWS(ROWS), .TAG_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_sob   (req_sob),
        .req_eob   (req_eob),
        .req_sof   (req_sof),
        .dct_valid (dct_valid),
        .dct_data  (dct_data),
        .dct_sob   (dct_sob),
        .dct_eob   (dct_eob),
        .dct_sof   (dct_sof),
        .dct_src   (dct_src),
`ifdef DCT_ARB_TAG_FIFO_EN
        .dct_out_valid (dct_valid),
        .dct_out_sob   (dct_sob),
        .out_src       (out_src),
        .out_src_valid (out_src_valid),
`endif
        .proto_err (proto_err)
    );

    row_t srcq [N][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   en_off_from = -1;
    int   en_off_to   = -1;

    // Model: which source owns an open block, rows taken so far, last finished owner.
    int   m_owner, m_nrows, m_last;
    logic e_valid, e_sob, e_eob, e_sof, e_err;
    logic [DW-1:0] e_data;
    int   e_src;

    int   n_valid, n_err, n_sof, first_v, last_v;
    int   sob_cyc[$], sob_src[$], eob_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic push_block(input int s, input int nrows, input int eob_row,
                              input bit sof, input int base);
        for (int r = 0; r < nrows; r++) begin
            row_t    x;
            logic [W_I-1:0] px;
            px     = W_I'(base + r);
            x.data = {8{px}};
            x.sob  = (r == 0);
            x.eob  = (r == eob_row);
            x.sof  = sof && (r == 0);
            srcq[s].push_back(x);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; en = 1'b0;
        req_valid = '0; req_sob = '0; req_eob = '0; req_sof = '0; req_data = '0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        @(negedge clk);
        chk("rst_dct_valid", dct_valid, 0);
        chk("rst_dct_sob",   dct_sob,   0);
        chk("rst_dct_eob",   dct_eob,   0);
        chk("rst_dct_sof",   dct_sof,   0);
        chk("rst_dct_src",   dct_src,   0);
        chk("rst_dct_data",  dct_data,  0);
        chk("rst_proto_err", proto_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_owner = -1; m_nrows = 0; m_last = N - 1;
        e_valid = 0; e_sob = 0; e_eob = 0; e_sof = 0; e_err = 0; e_data = '0; e_src = 0;
        n_valid = 0; n_err = 0; n_sof = 0; first_v = -1; last_v = -1;
        sob_cyc.delete(); sob_src.delete(); eob_cyc.delete();
        en_off_from = -1; en_off_to = -1;
    endtask

    task automatic model_step(output logic [N-1:0] rdy);
        rdy = '0;
        e_valid = 0; e_sob = 0; e_eob = 0; e_sof = 0; e_err = 0;
        if (en) begin
            if (m_owner < 0) begin
                int w, d;
                w = -1; d = -1;
                for (int k = 1; k <= N; k++) begin
                    int s;
                    s = (m_last + k) % N;
                    if (w < 0 && req_valid[s] && req_sob[s]) w = s;
                end
                if (w >= 0) begin
                    rdy[w] = 1'b1;
                    e_valid = 1; e_sob = 1; e_src = w;
                    e_data = req_data[w*DW +: DW];
                    e_sof = req_sof[w]; e_eob = req_eob[w];
                    if (req_eob[w]) m_last = w;
                    else begin m_owner = w; m_nrows = 1; end
                end else begin
                    for (int s = 0; s < N; s++) if (d < 0 && req_valid[s]) d = s;
                    if (d >= 0) begin rdy[d] = 1'b1; e_err = 1; end
                end
            end else begin
                rdy[m_owner] = 1'b1;
                if (req_valid[m_owner]) begin
                    bit full;
                    m_nrows++;
                    full    = (m_nrows == ROWS);
                    e_valid = 1; e_src = m_owner;
                    e_data  = req_data[m_owner*DW +: DW];
                    e_eob   = req_eob[m_owner] || full;
                    e_err   = req_sob[m_owner] || req_sof[m_owner] || (req_eob[m_owner] != full);
                    if (e_eob) begin m_last = m_owner; m_owner = -1; end
                end
            end
        end
    endtask

    task automatic run(input int max_cyc, input bit must_drain);
        int drain, rem;
        drain = 0;
        for (int c = 0; c < max_cyc; c++) begin
            logic [N-1:0] m_rdy;
            @(posedge clk); #1;
            en = !(c >= en_off_from && c < en_off_to);
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0) begin
                    row_t x;
                    x = srcq[i][0];
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = x.data;
                    req_sob[i] = x.sob; req_eob[i] = x.eob; req_sof[i] = x.sof;
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_sob[i] = 1'b0; req_eob[i] = 1'b0; req_sof[i] = 1'b0;
                end
            end
            @(negedge clk);
            cyc = c;
            chk("dct_valid", dct_valid, e_valid);
            chk("proto_err", proto_err, e_err);
            if (e_valid) begin
                chk("dct_data", dct_data, e_data);
                chk("dct_sob",  dct_sob,  e_sob);
                chk("dct_eob",  dct_eob,  e_eob);
                chk("dct_sof",  dct_sof,  e_sof);
                chk("dct_src",  dct_src,  e_src);
            end
            if (dct_valid) begin
                n_valid++;
                if (first_v < 0) first_v = c;
                last_v = c;
                if (dct_sob) begin sob_cyc.push_back(c); sob_src.push_back(int'(dct_src)); end
                if (dct_eob) eob_cyc.push_back(c);
                if (dct_sof) n_sof++;
            end
            if (proto_err) n_err++;
            model_step(m_rdy);
            chk("req_ready", req_ready, m_rdy);
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
            rem = 0;
            for (int i = 0; i < N; i++) rem += srcq[i].size();
            if (rem == 0) drain++;
            if (must_drain && drain >= 3) break;
        end
        if (must_drain) begin
            rem = 0;
            for (int i = 0; i < N; i++) rem += srcq[i].size();
            chk("drain_timeout_rows_left", rem, 0);
        end
    endtask

    initial begin
        // Single block from source 1.
        do_reset();
        push_block(1, 8, 7, 0, 0);
        run(40, 1);
        chk("s1_n_valid", n_valid, 8);
        chk("s1_first",   first_v, 1);
        chk("s1_last",    last_v,  8);
        chk("s1_src",     qat(sob_src, 0), 1);
        chk("s1_eob_cyc", qat(eob_cyc, 0), 8);
        chk("s1_err",     n_err, 0);

        // Three simultaneous requesters, granted 0,1,2 back to back.
        do_reset();
        push_block(0, 8, 7, 1, 16);
        push_block(1, 8, 7, 0, 32);
        push_block(2, 8, 7, 0, 48);
        run(60, 1);
        chk("s2_n_valid", n_valid, 24);
        chk("s2_first",   first_v, 1);
        chk("s2_last",    last_v,  24);
        chk("s2_sob0",    qat(sob_cyc, 0), 1);
        chk("s2_sob1",    qat(sob_cyc, 1), 9);
        chk("s2_sob2",    qat(sob_cyc, 2), 17);
        chk("s2_src0",    qat(sob_src, 0), 0);
        chk("s2_src1",    qat(sob_src, 1), 1);
        chk("s2_src2",    qat(sob_src, 2), 2);
        chk("s2_sof",     n_sof, 1);
        chk("s2_err",     n_err, 0);

        // Early eob from source 0; round robin must move on to source 1.
        do_reset();
        push_block(0, 5, 4, 0, 0);
        push_block(0, 8, 7, 0, 64);
        push_block(1, 8, 7, 0, 100);
        run(60, 1);
        chk("s3_n_valid", n_valid, 21);
        chk("s3_err",     n_err, 1);
        chk("s3_eob0",    qat(eob_cyc, 0), 5);
        chk("s3_src1",    qat(sob_src, 1), 1);
        chk("s3_sob1",    qat(sob_cyc, 1), 6);
        chk("s3_src2",    qat(sob_src, 2), 0);
        chk("s3_sob2",    qat(sob_cyc, 2), 14);

        // Missing eob from source 2, then an orphan ninth row.
        do_reset();
        push_block(2, 9, -1, 0, 200);
        run(40, 1);
        chk("s4_n_valid", n_valid, 8);
        chk("s4_eob",     qat(eob_cyc, 0), 8);
        chk("s4_src",     qat(sob_src, 0), 2);
        chk("s4_err",     n_err, 2);

        // Enable dropped for 5 cycles after row 2 of a block.
        do_reset();
        en_off_from = 3; en_off_to = 8;
        push_block(1, 8, 7, 0, 0);
        run(40, 1);
        chk("s5_n_valid", n_valid, 8);
        chk("s5_first",   first_v, 1);
        chk("s5_last",    last_v,  13);
        chk("s5_eob",     qat(eob_cyc, 0), 13);
        chk("s5_err",     n_err, 0);

        // Reset in the middle of a block: the grant must be lost.
        do_reset();
        push_block(0, 8, 7, 0, 0);
        run(4, 0);
        do_reset();
        push_block(1, 8, 7, 0, 40);
        run(40, 1);
        chk("s6_n_valid", n_valid, 8);
        chk("s6_first",   first_v, 1);
        chk("s6_src",     qat(sob_src, 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
